oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The module SHALL have parameter DEST_BASE, default 16'hFE00, meaning the first destination address.
REQ-002 The module SHALL have parameter LENGTH, default 160, meaning the number of bytes per transfer.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-005 Port cpu_write_en SHALL be an input, 1 bit wide: a CPU write strobe to the DMA register (0xFF46).
REQ-006 Port cpu_wdata SHALL be an input, 8 bits wide, carrying the source page written by the CPU.
REQ-007 Port dma_bus_op SHALL be an output of type bus_op_t, carrying the bus operation (BUS_IDLE, BUS_READ or BUS_WRITE) to the memory.
REQ-008 Port dma_addr SHALL be an output, 16 bits wide, carrying the bus address.
REQ-009 Port dma_wdata SHALL be an output, 8 bits wide, carrying the bus write data.
REQ-010 Port dma_rdata SHALL be an input, 8 bits wide, carrying memory read data, valid in the cycle after a BUS_READ cycle.
REQ-011 Port dma_active SHALL be an output, 1 bit wide, high while a transfer is in progress.
REQ-012 Port src_page SHALL be an output, 8 bits wide, giving the readback value of the last written page.
REQ-013 Port done SHALL be an output, 1 bit wide, pulsing for one cycle when a transfer completes.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, START, READ and WRITE.
REQ-015 The byte index idx SHALL be an 8-bit register; the page register SHALL be 8 bits.
REQ-016 When cpu_write_en is sampled high in any state, the FSM SHALL latch page <= cpu_wdata, set idx <= 0 and go to START.
REQ-017 START SHALL last one cycle, with dma_bus_op = BUS_IDLE, and then go to READ.
REQ-018 In READ, the outputs SHALL be dma_bus_op = BUS_READ and dma_addr = {eff_page, idx}; the next state SHALL be WRITE.
REQ-019 eff_page SHALL equal page - 8'h20 when page >= 8'hE0 (echo-RAM mirror) and SHALL equal page otherwise.
REQ-020 In WRITE, the outputs SHALL be dma_bus_op = BUS_WRITE, dma_addr = DEST_BASE + idx and dma_wdata = dma_rdata (combinational pass-through).
REQ-021 From WRITE, if idx == LENGTH-1 the FSM SHALL go to IDLE; otherwise it SHALL set idx <= idx+1 and go to READ.
REQ-022 Each byte SHALL take 2 cycles; a transfer SHALL occupy 1 + 2*LENGTH cycles (321 at the default LENGTH), measured from START entry to IDLE entry.
REQ-023 In IDLE, the outputs SHALL be dma_bus_op = BUS_IDLE, dma_addr = 16'h0000 and dma_wdata = 8'h00.
REQ-024 In START, READ and WRITE, dma_wdata SHALL be 8'h00 whenever the state is not WRITE.
REQ-025 dma_active SHALL be high in START, READ and WRITE, and low in IDLE.
REQ-026 done SHALL be a registered output, high for exactly the one cycle following the final WRITE cycle.
REQ-027 A cpu_write_en that coincides with the final WRITE cycle SHALL take priority: the FSM restarts in START and done is not pulsed.
REQ-028 A cpu_write_en during START, READ or WRITE SHALL abort the current byte; the pending READ data SHALL be discarded and no write SHALL be issued for it.
REQ-029 src_page SHALL always equal the page register (the raw value, not eff_page).
REQ-030 Bus outputs SHALL be decoded from registered state only; there SHALL be no path from cpu_write_en to dma_bus_op within the same cycle.

Reset
REQ-031 While reset is low, the block SHALL immediately (asynchronously) set state = IDLE, idx = 0, page = 8'h00, done = 0, dma_active = 0, dma_bus_op = BUS_IDLE and dma_addr = 16'h0000.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.
REQ-033 After reset is released, the block SHALL issue no bus activity until the next cpu_write_en.

Verification
REQ-034 Reset test: hold reset low -> all outputs at their reset values; deassert -> dma_bus_op stays BUS_IDLE for 10 cycles.
REQ-035 Basic copy test: memory C100+i = i^8'h5A; write page 8'hC1 -> first READ at 0xC100 two cycles after the strobe edge; FE00..FE9F hold i^8'h5A; done pulses exactly once, 321 cycles after START entry.
REQ-036 Restart test: write 8'h80 while idx = 50 -> the next cycle is START, the next READ address is 0x8000, the full 160 bytes are copied from page 0x80, and exactly one done pulse occurs.
REQ-037 Mirror test: write 8'hE3 -> reads cover 0xC300..0xC39F; src_page reads 8'hE3.
REQ-038 Async reset test: drop reset between clock edges at idx = 20 -> dma_bus_op = BUS_IDLE and dma_active = 0 before the next edge; no done pulse follows.
REQ-039 Final-cycle collision test: cpu_write_en (8'hD0) coincident with the WRITE of idx 159 -> done stays 0, START follows, and the next READ is at 0xD000.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma -- sprite-attribute DMA engine.
// A CPU write to the DMA register latches a source page and copies LENGTH
// bytes from {page,idx} to DEST_BASE+idx, one byte every two cycles
// (READ then WRITE). The read data returns the cycle after the READ, so
// it is passed straight through to the bus during WRITE.
// Ports:
//   clk, reset (async, active low)
//   cpu_write_en, cpu_wdata : CPU strobe / source page
//   dma_bus_op, dma_addr, dma_wdata, dma_rdata : memory bus
//   dma_active : transfer in progress
//   src_page   : readback of the raw page register
//   done       : one-cycle pulse after the final write
package oam_dma_pkg;
  typedef enum logic [1:0] {BUS_IDLE, BUS_READ, BUS_WRITE} bus_op_t;
endpackage

module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DEST_BASE = 16'hFE00,
  parameter int          LENGTH    = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_write_en,
  input  logic [7:0]  cpu_wdata,
  output bus_op_t     dma_bus_op,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  input  logic [7:0]  dma_rdata,
  output logic        dma_active,
  output logic [7:0]  src_page,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t     state, state_n;
  logic [7:0] idx, idx_n;
  logic [7:0] page, page_n;
  logic       done_n;
  logic [7:0] eff_page;

  // Pages E0..FF mirror work RAM C0..DF.
  assign eff_page = (page >= 8'hE0) ? (page - 8'h20) : page;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= 8'h00;
      page  <= 8'h00;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      page  <= page_n;
      done  <= done_n;
    end
  end

  // A CPU strobe overrides everything, including the final write, so a
  // colliding restart never produces a done pulse.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    page_n  = page;
    done_n  = 1'b0;
    if (cpu_write_en) begin
      page_n  = cpu_wdata;
      idx_n   = 8'h00;
      state_n = START;
    end else begin
      case (state)
        IDLE:  state_n = IDLE;
        START: state_n = READ;
        READ:  state_n = WRITE;
        WRITE: begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 8'h01;
            state_n = READ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Bus outputs depend on registered state only (plus the read-data
  // pass-through), never on the CPU strobe.
  always_comb begin
    dma_bus_op = BUS_IDLE;
    dma_addr   = 16'h0000;
    dma_wdata  = 8'h00;
    case (state)
      READ: begin
        dma_bus_op = BUS_READ;
        dma_addr   = {eff_page, idx};
      end
      WRITE: begin
        dma_bus_op = BUS_WRITE;
        dma_addr   = DEST_BASE + {8'h00, idx};
        dma_wdata  = dma_rdata;
      end
      default: ;
    endcase
  end

  assign dma_active = (state != IDLE);
  assign src_page   = page;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;
  import oam_dma_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_write_en;
  logic [7:0]  cpu_wdata;
  bus_op_t     dma_bus_op;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_active;
  logic [7:0]  src_page;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  logic [7:0] dst [0:255];

  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_write_en(cpu_write_en), .cpu_wdata(cpu_wdata),
    .dma_bus_op(dma_bus_op), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_active(dma_active), .src_page(src_page), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory contents, one pattern per page used by the tests.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    case (a[15:8])
      8'hC1:   return a[7:0] ^ 8'h5A;
      8'h80:   return a[7:0] ^ 8'h33;
      8'hC3:   return a[7:0] ^ 8'hA5;
      8'hD0:   return a[7:0] + 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  // Memory: read data registered (valid the cycle after READ); OAM writes captured.
  always @(posedge clk) begin
    dma_rdata <= src_byte(dma_addr);
    if (dma_bus_op == BUS_WRITE && dma_addr[15:8] == 8'hFE) dst[dma_addr[7:0]] <= dma_wdata;
  end

  always @(posedge clk) if (done === 1'b1) done_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse the strobe starting now; returns at the next falling edge (in START).
  task automatic strobe(input logic [7:0] v);
    cpu_write_en = 1'b1;
    cpu_wdata    = v;
    @(negedge clk);
    cpu_write_en = 1'b0;
  endtask

  task automatic wait_for(input bus_op_t op, input logic [15:0] a, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dma_bus_op == op && dma_addr == a) && n < 400);
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  // Called in START; follows the transfer to IDLE, checking every bus cycle.
  task automatic xfer(input logic [15:0] rbase, output int cyc, output int rds, output int bad);
    int wrs = 0;
    cyc = 0; rds = 0; bad = 0;
    while (dma_active && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (dma_bus_op == BUS_READ) begin
        if (dma_addr !== 16'(rbase + rds)) bad++;
        rds++;
      end else if (dma_bus_op == BUS_WRITE) begin
        if (dma_addr !== 16'(16'hFE00 + wrs) || dma_wdata !== src_byte(16'(rbase + wrs))) bad++;
        wrs++;
      end
    end
  endtask

  initial begin
    int cyc, rds, bad, d0, nbad;
    reset = 1'b1; cpu_write_en = 1'b0; cpu_wdata = 8'h00;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_op",     32'(dma_bus_op), 32'(BUS_IDLE));
    chk("rst_addr",   32'(dma_addr),   32'h0000);
    chk("rst_wdata",  32'(dma_wdata),  32'h00);
    chk("rst_active", 32'(dma_active), 32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_page",   32'(src_page),   32'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    nbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (dma_bus_op !== BUS_IDLE || dma_active !== 1'b0) nbad++;
    end
    chk("post_rst_idle", 32'(nbad), 32'd0);

    // Basic copy from page C1
    d0 = done_total;
    strobe(8'hC1);
    chk("basic_start_op",  32'(dma_bus_op), 32'(BUS_IDLE));
    chk("basic_start_act", 32'(dma_active), 32'd1);
    xfer(16'hC100, cyc, rds, bad);
    chk("basic_cycles", 32'(cyc), 32'd321);
    chk("basic_reads",  32'(rds), 32'd160);
    chk("basic_bus",    32'(bad), 32'd0);
    chk("basic_done_hi", 32'(done), 32'd1);
    @(negedge clk);
    chk("basic_done_lo", 32'(done), 32'd0);
    nbad = 0;
    for (int i = 0; i < 160; i++) if (dst[i] !== (8'(i) ^ 8'h5A)) nbad++;
    chk("basic_oam", 32'(nbad), 32'd0);
    chk("basic_done_cnt", 32'(done_total - d0), 32'd1);

    // Restart at idx 50 with page 80
    d0 = done_total;
    strobe(8'hC1);
    wait_for(BUS_READ, 16'hC132, "restart_reach");
    strobe(8'h80);
    chk("restart_start_op",  32'(dma_bus_op), 32'(BUS_IDLE));
    chk("restart_start_act", 32'(dma_active), 32'd1);
    chk("restart_page",      32'(src_page),   32'h80);
    xfer(16'h8000, cyc, rds, bad);
    chk("restart_cycles", 32'(cyc), 32'd321);
    chk("restart_reads",  32'(rds), 32'd160);
    chk("restart_bus",    32'(bad), 32'd0);
    @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 160; i++) if (dst[i] !== (8'(i) ^ 8'h33)) nbad++;
    chk("restart_oam", 32'(nbad), 32'd0);
    chk("restart_done_cnt", 32'(done_total - d0), 32'd1);

    // Echo-RAM mirror: page E3 reads C3xx
    strobe(8'hE3);
    chk("mirror_page", 32'(src_page), 32'hE3);
    xfer(16'hC300, cyc, rds, bad);
    chk("mirror_reads", 32'(rds), 32'd160);
    chk("mirror_bus",   32'(bad), 32'd0);
    @(negedge clk);

    // Asynchronous reset at idx 20
    d0 = done_total;
    strobe(8'hC1);
    wait_for(BUS_READ, 16'hC114, "arst_reach");
    #2 reset = 1'b0;
    #1;
    chk("arst_op",     32'(dma_bus_op), 32'(BUS_IDLE));
    chk("arst_active", 32'(dma_active), 32'd0);
    chk("arst_addr",   32'(dma_addr),   32'h0000);
    chk("arst_page",   32'(src_page),   32'h00);
    @(negedge clk);
    reset = 1'b1;
    nbad = 0;
    repeat (12) begin
      @(negedge clk);
      if (dma_bus_op !== BUS_IDLE || dma_active !== 1'b0) nbad++;
    end
    chk("arst_quiet", 32'(nbad), 32'd0);
    chk("arst_no_done", 32'(done_total - d0), 32'd0);

    // Strobe colliding with the final WRITE
    strobe(8'hC1);
    wait_for(BUS_WRITE, 16'hFE9F, "coll_reach");
    d0 = done_total;
    strobe(8'hD0);
    chk("coll_done",      32'(done),       32'd0);
    chk("coll_start_op",  32'(dma_bus_op), 32'(BUS_IDLE));
    chk("coll_start_act", 32'(dma_active), 32'd1);
    @(negedge clk);
    chk("coll_read_op",   32'(dma_bus_op), 32'(BUS_READ));
    chk("coll_read_addr", 32'(dma_addr),   32'hD000);
    chk("coll_no_done",   32'(done_total - d0), 32'd0);
    nbad = 0;
    while (dma_active && nbad < 400) begin
      @(negedge clk);
      nbad++;
    end
    chk("coll_finish", 32'(nbad < 400), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
